// File: rtl/trap_ctrl_plic.sv
`default_nettype none
// ============================================================================
// Module  : trap_ctrl_plic
// Brief   : WB-stage trap controller; merges exceptions, mret and interrupts
//           into one prioritised redirect and drives the CSR update values.
// Revision: 1.0 - initial release
// ============================================================================
module trap_ctrl_plic #(
  parameter int unsigned NUM_LOCAL   = 4,
  parameter logic [15:0] LOCAL_EDGE  = 16'h0000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_valid,
  input  logic                    wb_flush,
  input  logic [31:0]             pc,
  input  logic [31:0]             fault_address,
  input  logic [31:0]             fault_instruction,
  input  logic [3:0]              exc,
  input  logic                    mret,
  input  logic                    software_interrupt,
  input  logic                    timer_interrupt,
  input  logic                    external_interrupt,
  input  logic [NUM_LOCAL-1:0]    local_interrupt,
  input  logic [29:0]             i_mtvec_base,
  input  logic [1:0]              i_mtvec_mode,
  input  logic                    i_mstatus_mie,
  input  logic                    i_mstatus_mpie,
  input  logic [31:0]             i_mepc_value,
  input  logic [16+NUM_LOCAL-1:0] i_mie,
  output logic [16+NUM_LOCAL-1:0] o_mip,
  output logic                    trap_take,
  output logic [31:0]             trap_pc,
  output logic                    o_mcause_interrupt,
  output logic [30:0]             o_mcause_exception_code,
  output logic [31:0]             o_mepc_value,
  output logic [31:0]             o_mtval_value,
  output logic                    o_mstatus_mie,
  output logic                    o_mstatus_mpie,
  output logic [1:0]              o_mstatus_mpp
);

  localparam int unsigned c_W         = 16 + NUM_LOCAL;
  localparam int unsigned c_CNT_W     = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned c_HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic [c_W-1:0] w_raw, w_edge_mask, w_sync;
  logic [c_W-1:0] r_prev, r_edge, r_lvl;
  logic [c_W-1:0] w_cand, w_clr;
  logic           w_int_any, w_exc_any, w_accept;
  logic           w_take_int, w_take_exc, w_take_mret;
  logic [4:0]     w_int_cause;
  logic [30:0]    w_exc_code;
  logic [31:0]    w_exc_tval;
  logic [31:0]    w_base_pc;

  // Interrupt inputs are carried in mip bit positions from the pin onwards.
  always_comb begin
    w_raw       = '0;
    w_edge_mask = '0;
    w_raw[3]    = software_interrupt;
    w_raw[7]    = timer_interrupt;
    w_raw[11]   = external_interrupt;
    for (int i = 0; i < NUM_LOCAL; i++) begin
      w_raw[16+i]       = local_interrupt[i];
      w_edge_mask[16+i] = LOCAL_EDGE[i];
    end
  end

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign w_sync = w_raw;
    end else begin : g_sync
      logic [c_W-1:0] r_stage [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (rst) begin
          r_stage <= '{default: '0};
        end else begin
          r_stage[0] <= w_raw;
          for (int s = 1; s < SYNC_STAGES; s++) begin
            r_stage[s] <= r_stage[s-1];
          end
        end
      end
      assign w_sync = r_stage[SYNC_STAGES-1];
    end
  endgenerate

  // Edge latch: a fresh rising edge wins over a clear from a trap taken the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev <= '0;
      r_edge <= '0;
      r_lvl  <= '0;
    end else begin
      r_prev <= w_sync;
      r_edge <= ((w_sync & ~r_prev) | (r_edge & ~w_clr)) & w_edge_mask;
      r_lvl  <= w_sync & ~w_edge_mask;
    end
  end

  assign o_mip  = rst ? '0 : (r_lvl | r_edge);
  assign w_cand = o_mip & i_mie & {c_W{i_mstatus_mie}};

  // Later assignments override earlier ones, so the loop ends with the highest priority.
  always_comb begin
    w_int_any   = 1'b0;
    w_int_cause = '0;
    for (int i = 0; i < NUM_LOCAL; i++) begin
      if (w_cand[16+i]) begin
        w_int_any   = 1'b1;
        w_int_cause = 5'(16 + i);
      end
    end
    if (w_cand[7]) begin
      w_int_any   = 1'b1;
      w_int_cause = 5'd7;
    end
    if (w_cand[3]) begin
      w_int_any   = 1'b1;
      w_int_cause = 5'd3;
    end
    if (w_cand[11]) begin
      w_int_any   = 1'b1;
      w_int_cause = 5'd11;
    end
  end

  always_comb begin
    w_exc_any  = |exc;
    w_exc_code = '0;
    w_exc_tval = '0;
    if (exc[0]) begin
      w_exc_code = 31'd0;
      w_exc_tval = fault_address;
    end else if (exc[1]) begin
      w_exc_code = 31'd2;
      w_exc_tval = fault_instruction;
    end else if (exc[2]) begin
      w_exc_code = 31'd4;
      w_exc_tval = fault_address;
    end else if (exc[3]) begin
      w_exc_code = 31'd6;
      w_exc_tval = fault_address;
    end
  end

  assign w_accept    = wb_valid & ~wb_flush & (r_state == ST_IDLE) & ~rst;
  assign w_take_int  = w_accept & w_int_any;
  assign w_take_exc  = w_accept & ~w_int_any & w_exc_any;
  assign w_take_mret = w_accept & ~w_int_any & ~w_exc_any & mret;
  assign w_base_pc   = {i_mtvec_base, 2'b00};
  assign w_clr       = w_take_int ? (c_W'(1) << w_int_cause) : '0;

  always_comb begin
    trap_take               = w_take_int | w_take_exc | w_take_mret;
    trap_pc                 = '0;
    o_mcause_interrupt      = 1'b0;
    o_mcause_exception_code = '0;
    o_mtval_value           = '0;
    o_mepc_value            = rst ? '0 : pc;
    o_mstatus_mie           = rst ? 1'b0 : i_mstatus_mie;
    o_mstatus_mpie          = rst ? 1'b0 : i_mstatus_mpie;
    o_mstatus_mpp           = rst ? 2'b00 : 2'b11;
    if (w_take_int) begin
      trap_pc                 = (i_mtvec_mode == 2'd1) ?
                                w_base_pc + {25'd0, w_int_cause, 2'b00} : w_base_pc;
      o_mcause_interrupt      = 1'b1;
      o_mcause_exception_code = {26'd0, w_int_cause};
      o_mstatus_mie           = 1'b0;
      o_mstatus_mpie          = i_mstatus_mie;
    end else if (w_take_exc) begin
      trap_pc                 = w_base_pc;
      o_mcause_exception_code = w_exc_code;
      o_mtval_value           = w_exc_tval;
      o_mstatus_mie           = 1'b0;
      o_mstatus_mpie          = i_mstatus_mie;
    end else if (w_take_mret) begin
      trap_pc        = i_mepc_value;
      o_mstatus_mie  = i_mstatus_mpie;
      o_mstatus_mpie = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Hold-off lets the pipeline drain after a redirect before another is accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (trap_take && (HOLD_CYCLES > 0)) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = c_CNT_W'(c_HOLD_LOAD);
        end
      end
      ST_HOLD: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire
